// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : State encodings, baud-timing helpers and frame constants for
//               the UART byte receiver. UART_RX_PARITY_EN selects 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
    localparam int STATE_W    = 5;
    localparam int FRAME_BITS = 11;

    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_START  = 5'b00010;
    localparam logic [4:0] ST_DATA   = 5'b00100;
    localparam logic [4:0] ST_STOP   = 5'b01000;
    localparam logic [4:0] ST_PARITY = 5'b10000;
`else
    localparam int STATE_W    = 4;
    localparam int FRAME_BITS = 10;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_START = 4'b0010;
    localparam logic [3:0] ST_DATA  = 4'b0100;
    localparam logic [3:0] ST_STOP  = 4'b1000;
`endif

    function automatic int baud_cnt_max(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

    function automatic int baud_mid(input int cnt_max);
        return cnt_max / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the serial line plus a history flop
//               giving a registered falling-edge indication.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall_edge
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic hist_q, hist_d;

    always_comb begin
        meta_d = rx;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    // Reset to 1 so a released reset never looks like a start edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rx_s      = sync_q;
    assign fall_edge = hist_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART byte receiver (8E1 when UART_RX_PARITY_EN is defined)
//               producing one-cycle po_flag / po_err strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 9600
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       po_err
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int BAUD_MID     = baud_mid(BAUD_CNT_MAX);
    localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(BAUD_MID);
    localparam logic [3:0]       BITS_DONE = 4'(DATA_BITS);

    logic rx_s;
    logic fall_edge;

    uart_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .rx_s      (rx_s),
        .fall_edge (fall_edge)
    );

    logic [STATE_W-1:0] state_q,    state_d;
    logic [CNT_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [3:0]         bit_cnt_q,  bit_cnt_d;
    logic [7:0]         shift_q,    shift_d;
    logic [7:0]         data_q,     data_d;
    logic               flag_q,     flag_d;
    logic               err_q,      err_d;
    logic               par_err;
    logic               at_mid;
    logic               at_last;

`ifdef UART_RX_PARITY_EN
    logic               par_err_q,  par_err_d;
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign at_mid  = (baud_cnt_q == CNT_MID);
    assign at_last = (baud_cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        flag_d     = 1'b0;
        err_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d  = par_err_q;
`endif
        if (state_q != ST_IDLE) begin
            baud_cnt_d = at_last ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (fall_edge) begin
                    state_d = ST_START;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (at_mid && rx_s) begin
                    state_d    = ST_IDLE;
                    baud_cnt_d = '0;
                end else if (at_last) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 4'd0;
                end
            end
            ST_DATA: begin
                if (at_mid) begin
                    shift_d[bit_cnt_q[2:0]] = rx_s;
                    bit_cnt_d               = bit_cnt_q + 4'd1;
                end
                if (at_last && (bit_cnt_q == BITS_DONE)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (at_mid) begin
                    par_err_d = (rx_s != ^shift_q);
                end
                if (at_last) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leave at mid-bit so a start bit right after the stop bit is caught.
                if (at_mid) begin
                    state_d    = ST_IDLE;
                    baud_cnt_d = '0;
                    if (rx_s && !par_err) begin
                        data_d = shift_q;
                        flag_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            data_q     <= 8'd0;
            flag_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            flag_q     <= flag_d;
            err_q      <= err_d;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign po_data = data_q;
    assign po_flag = flag_q;
    assign po_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_byte
// Description : Randomised self-checking bench for uart_rx_byte against a
//               frame-level reference model (8N1, or 8E1 with UART_RX_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int CLK_FREQ = 1000;
    localparam int UART_BPS = 100;
    localparam int BIT      = CLK_FREQ / UART_BPS;
    localparam int MID      = BIT / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN       = 1'b1;
    localparam int BITS_TO_STOP = 10;
`else
    localparam bit PAR_EN       = 1'b0;
    localparam int BITS_TO_STOP = 9;
`endif
    // rx drop -> 2 sync edges + 1 edge into START, then bits up to the stop
    // mid-sample, then the strobe registers one edge later.
    localparam int FLAG_LAT = 3 + BITS_TO_STOP * BIT + MID + 1;

    typedef struct packed {
        logic [1:0]  kind;   // {flag, err}
        logic [7:0]  data;
        logic [31:0] cyc;
    } ev_t;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        rx        = 1'b1;
    logic [7:0]  po_data;
    logic        po_flag;
    logic        po_err;
    logic [31:0] cyc       = '0;
    logic [7:0]  last_good = 8'd0;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .po_err    (po_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(posedge sys_clk) begin
        #1;
        if (po_flag || po_err)
            obs_q.push_back(ev_t'{kind: {po_flag, po_err}, data: po_data, cyc: cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    // Frame-level model: a frame is good iff the stop bit is 1 (and, with
    // parity, the parity bit makes the ones count even).
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        ev_t e;
        logic good;
        good = stop_b && (!PAR_EN || (par_b == ^d));
        if (good) begin
            last_good = d;
            e.kind    = 2'b10;
        end else begin
            e.kind    = 2'b01;
        end
        e.data = last_good;
        e.cyc  = cyc + FLAG_LAT;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par_b);
        drive_bit(stop_b);
        check("po_data_hold", {24'd0, po_data}, {24'd0, last_good});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 sys_rst_n = 1'b0;
        #1;
        check("rst_po_data", {24'd0, po_data}, 32'd0);
        check("rst_po_flag", {31'd0, po_flag}, 32'd0);
        check("rst_po_err",  {31'd0, po_err},  32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(10);

        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(7);

        // Back-to-back: next start bit directly after the stop bit.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(5);

        // Short low glitch must not start a frame.
        rx = 1'b0;
        repeat (3) @(negedge sys_clk);
        idle(12);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle(4);

        send_frame(8'h3C, 1'b0, ^8'h3C);
        idle(6);

        // Stuck-low line: one framing error only.
        send_frame(8'h00, 1'b0, 1'b0);
        repeat (150) @(negedge sys_clk);
        idle(6);

        // Reset during data bit 4 of 8'h81.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i == 0);
        rx = 1'b0;
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        rx        = 1'b1;
        #1;
        check("midrst_po_data", {24'd0, po_data}, 32'd0);
        check("midrst_po_flag", {31'd0, po_flag}, 32'd0);
        check("midrst_po_err",  {31'd0, po_err},  32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        last_good = 8'd0;
        idle(20);
        check("post_rst_po_data", {24'd0, po_data}, 32'd0);
        send_frame(8'h42, 1'b1, ^8'h42);
        idle(5);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(5);
`endif

        for (int n = 0; n < 12; n++) begin
            logic [7:0] d;
            logic       s;
            logic       p;
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            p = (^d) ^ ($urandom_range(0, 4) == 0);
            send_frame(d, s, p);
            idle(int'($urandom_range(s ? 0 : 1, 8)));
        end

        idle(30);

        check("event_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("ev%0d_kind", i), {30'd0, obs_q[i].kind}, {30'd0, exp_q[i].kind});
            check($sformatf("ev%0d_data", i), {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
            check($sformatf("ev%0d_cycle", i), obs_q[i].cyc, exp_q[i].cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial byte receiver (8N1, LSB first) that feeds the SPI flash sequential-write controller.
- Converts the asynchronous `rx` line into a one-cycle `po_flag` strobe plus `po_data`, which connect directly to the writer's `pi_flag`/`pi_data`.
- Discards malformed frames and reports each one on `po_err`.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- UART_BPS, 9600: baud rate. BAUD_CNT_MAX = CLK_FREQ/UART_BPS, integer division (5208 at defaults).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous active-low reset.
- rx  input  1  asynchronous serial line; idle high.
- po_data  output  8  last good received byte.
- po_flag  output  1  one-cycle strobe: po_data is valid and new.
- po_err  output  1  one-cycle strobe: frame discarded.

Behaviour:
- Reset (async, active-low):
  - po_data=8'd0, po_flag=0, po_err=0.
  - State IDLE; all counters 0.
  - Synchroniser flops reset to 1 (line idle).
- Input conditioning:
  - rx passes through a 2-flop synchroniser (rx_s) plus one history flop (rx_d).
  - Start edge = rx_d==1 && rx_s==0.
- State machine, one-hot 4 bits: IDLE=0001, START=0010, DATA=0100, STOP=1000.
- IDLE:
  - On a start edge, go to START and clear baud_cnt.
  - Other edges are ignored.
- baud_cnt:
  - Counts 0..BAUD_CNT_MAX-1 in every non-IDLE state.
  - Wraps to 0 at BAUD_CNT_MAX-1.
  - Mid-bit sample point is baud_cnt==BAUD_CNT_MAX/2 ("mid").
- START:
  - At mid, if rx_s==1 (glitch), return to IDLE with no strobe.
  - At mid, if rx_s==0, stay in START until the baud_cnt wrap, then go to DATA with bit_cnt=0.
- DATA:
  - At each mid, shift rx_s into shift_reg[bit_cnt] (LSB first), then bit_cnt+1.
  - After bit_cnt==7 and the wrap, go to STOP.
- STOP:
  - At mid, if rx_s==1: on the next edge, po_data<=shift_reg and po_flag pulses for 1 cycle.
  - At mid, if rx_s==0 (framing error): po_err pulses for 1 cycle and po_data is unchanged.
  - Either way, return to IDLE at mid, not at end of bit, so back-to-back frames are caught.
- Latency: po_flag rises exactly 1 sys_clk after the stop-bit mid-sample cycle.
- Strobes are never asserted together, and never for more than 1 cycle.
- po_data holds its value between strobes; the consumer may sample it at any time after po_flag.
- Line held low: a frame is seen as a framing error.
  - After that, IDLE re-arms only on a fresh 1→0 edge.
  - A stuck-low line yields exactly one po_err.
- Reset mid-frame: immediate return to IDLE and outputs cleared; the partial byte is lost, no strobe.
- Rate: no overrun is possible toward the flash writer only if the byte interval exceeds the writer's ~352-cycle write sequence. At 9600 bps the interval is ~52k cycles, so the receiver keeps no FIFO.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit follows D7, and a PARITY state (one-hot width becomes 5, PARITY=10000) sits between DATA and STOP.
  - At the parity mid-sample, compare rx_s with ^shift_reg and latch a mismatch flag.
  - At the stop mid-sample, a parity mismatch OR a framing error gives a po_err pulse and no po_flag.
- Undefined: 8N1 as above; no PARITY state; po_err reports framing and glitch-free-frame errors only.

Decomposition:
- Package uart_pkg holds:
  - state encodings;
  - BAUD_CNT_MAX and BAUD_MID derivation functions;
  - frame-length constants, which depend on UART_RX_PARITY_EN.
- One sub-module, uart_rx_sync: 2-flop synchroniser plus history flop.
  - Outputs rx_s and fall_edge.
  - Reset value 1; async active-low reset.
- The FSM, counters and shift register stay in uart_rx_byte.

Test Plan:
All cases use bench parameters CLK_FREQ=1000, UART_BPS=100, giving 10 cycles/bit and mid=5.
- Send 8'hA5 (8N1): po_flag high 1 cycle; po_data==8'hA5 1 cycle after stop mid; po_err stays 0.
- Send 8'h00 then 8'hFF back-to-back, with the second start edge on the cycle after the first stop bit ends: two po_flag pulses, data 00 then FF.
- Low glitch of 3 cycles on idle rx: no po_flag, no po_err, FSM back in IDLE by cycle 6.
- Send 8'h3C with stop bit driven 0: po_err one pulse; po_flag 0; po_data keeps its previous value.
- Assert sys_rst_n=0 during DATA bit 4 of 8'h81, then release and send 8'h42: outputs 0 during reset; only 8'h42 is reported.
- With UART_RX_PARITY_EN, send 8'h07 with parity bit 1 (correct, odd ones count) and then with parity bit 0: po_flag with 8'h07 for the first frame, po_err for the second.
